// File: rtl/alu_pkg.sv
// ALU funct codes and helpers used by the ALU sharing logic.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SLT = 6'b101010;
    localparam logic [5:0] OP_NOP = 6'b000000;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT: is_legal_op = 1'b1;
            default:                                       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: search starts one past the last winner, pointer moves only on a grant.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_any
);

    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

    assign grant_any = found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(NREQ - 1);
        end else if (found) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NREQ requesters; results return through one-entry buffers.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_in1,
    input  logic [NREQ*WIDTH-1:0] req_in2,
    input  logic [NREQ*6-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*WIDTH-1:0] rsp_res,
    output logic [NREQ-1:0]       rsp_err,
    output logic [WIDTH-1:0]      alu_in1,
    output logic [WIDTH-1:0]      alu_in2,
    output logic [5:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_res
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic             issue;
    logic [WIDTH-1:0] win_in1;
    logic [WIDTH-1:0] win_in2;
    logic [5:0]       win_op;
    logic             win_legal;

    logic             infl_vld_p1;
    logic [IDW-1:0]   infl_id_p1;
    logic             infl_err_p1;

    // A requester with an op in the ALU, or a full unpopped buffer, must wait.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i]
                        && !(infl_vld_p1 && infl_id_p1 == IDW'(i))
                        && !(rsp_valid[i] && !rsp_ready[i]);
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (eligible),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready = grant & {NREQ{rst_n}};
    assign issue     = grant_any & rst_n;

    always_comb begin
        win_in1 = '0;
        win_in2 = '0;
        win_op  = OP_NOP;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                win_in1 = req_in1[i*WIDTH +: WIDTH];
                win_in2 = req_in2[i*WIDTH +: WIDTH];
                win_op  = req_op[i*6 +: 6];
            end
        end
    end

    assign win_legal = is_legal_op(win_op);
    assign alu_in1   = (issue && win_legal) ? win_in1 : '0;
    assign alu_in2   = (issue && win_legal) ? win_in2 : '0;
    assign alu_op    = (issue && win_legal) ? win_op  : OP_NOP;

    // p1: op is inside the ALU; its result is on alu_res during the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_vld_p1 <= 1'b0;
            infl_id_p1  <= '0;
            infl_err_p1 <= 1'b0;
        end else begin
            infl_vld_p1 <= issue;
            infl_id_p1  <= grant_id;
            infl_err_p1 <= !win_legal;
        end
    end

    // p2: capture into the owner's response buffer, or pop it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_res   <= '0;
            rsp_err   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (infl_vld_p1 && infl_id_p1 == IDW'(i)) begin
                    rsp_valid[i]              <= 1'b1;
                    rsp_res[i*WIDTH +: WIDTH] <= infl_err_p1 ? '0 : alu_res;
                    rsp_err[i]                <= infl_err_p1;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table plus hand sequences and a scoreboarded random mix for alu_arbiter.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ  = 2;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_in1;
    logic [NREQ*WIDTH-1:0] req_in2;
    logic [NREQ*6-1:0]     req_op;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [NREQ*WIDTH-1:0] rsp_res;
    logic [NREQ-1:0]       rsp_err;
    logic [WIDTH-1:0]      alu_in1;
    logic [WIDTH-1:0]      alu_in2;
    logic [5:0]            alu_op;
    logic [WIDTH-1:0]      alu_res;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_op    (alu_op),
        .alu_res   (alu_res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  alu_ref = a + b;
            OP_SUB:  alu_ref = a - b;
            OP_AND:  alu_ref = a & b;
            OP_OR:   alu_ref = a | b;
            OP_NOR:  alu_ref = ~(a | b);
            OP_SLT:  alu_ref = (a < b) ? 32'd1 : 32'd0;
            default: alu_ref = 32'd0;
        endcase
    endfunction

    // Registered ALU model: NOP holds the previous result.
    always @(posedge clk) begin
        if (alu_op != OP_NOP) alu_res <= alu_ref(alu_op, alu_in1, alu_in2);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int i, input logic v, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        req_valid[i]          = v;
        req_op[i*6 +: 6]      = op;
        req_in1[i*WIDTH +: 32] = a;
        req_in2[i*WIDTH +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        req_op    = '0;
        rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [5:0]  op0;
        logic [31:0] a0, b0;
        logic [5:0]  op1;
        logic [31:0] a1, b1;
        logic [1:0]  x_rdy;
        logic [5:0]  x_op;
        logic [31:0] x_in1;
        logic [1:0]  x_rvld;
        logic [31:0] x_res0, x_res1;
        logic [1:0]  x_err;
    } vec_t;

    localparam int NV = 13;
    vec_t vt[NV];

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [5:0]  ops[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          issued;
        logic [1:0]  acc;
        logic [31:0] a, b, expv;
        logic [5:0]  op;

        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT};

        //       vld    op0     a0            b0            op1       a1            b1            rdy    x_op    x_in1         rvld   res0          res1          err
        vt[0]  = '{2'b11, OP_SUB, 32'd9,        32'd4,        OP_SLT,   32'd3,        32'd8,        2'b01, OP_SUB, 32'd9,        2'b00, 32'd0,        32'd0,        2'b00};
        vt[1]  = '{2'b10, OP_SUB, 32'd9,        32'd4,        OP_SLT,   32'd3,        32'd8,        2'b10, OP_SLT, 32'd3,        2'b00, 32'd0,        32'd0,        2'b00};
        vt[2]  = '{2'b00, OP_NOP, 32'd0,        32'd0,        OP_NOP,   32'd0,        32'd0,        2'b00, OP_NOP, 32'd0,        2'b01, 32'd5,        32'd0,        2'b00};
        vt[3]  = '{2'b00, OP_NOP, 32'd0,        32'd0,        OP_NOP,   32'd0,        32'd0,        2'b00, OP_NOP, 32'd0,        2'b10, 32'd0,        32'd1,        2'b00};
        vt[4]  = '{2'b11, OP_ADD, 32'd5,        32'd7,        OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 2'b01, OP_ADD, 32'd5,        2'b00, 32'd0,        32'd0,        2'b00};
        vt[5]  = '{2'b10, OP_ADD, 32'd5,        32'd7,        OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 2'b10, OP_AND, 32'hF0F0F0F0, 2'b00, 32'd0,        32'd0,        2'b00};
        vt[6]  = '{2'b11, OP_OR,  32'h0F0F0000, 32'h000000F0, OP_NOR,   32'd0,        32'd0,        2'b01, OP_OR,  32'h0F0F0000, 2'b01, 32'd12,       32'd0,        2'b00};
        vt[7]  = '{2'b10, OP_OR,  32'h0F0F0000, 32'h000000F0, OP_NOR,   32'd0,        32'd0,        2'b10, OP_NOR, 32'd0,        2'b10, 32'd0,        32'hF000F000, 2'b00};
        vt[8]  = '{2'b00, OP_NOP, 32'd0,        32'd0,        OP_NOP,   32'd0,        32'd0,        2'b00, OP_NOP, 32'd0,        2'b01, 32'h0F0F00F0, 32'd0,        2'b00};
        vt[9]  = '{2'b00, OP_NOP, 32'd0,        32'd0,        OP_NOP,   32'd0,        32'd0,        2'b00, OP_NOP, 32'd0,        2'b10, 32'd0,        32'hFFFFFFFF, 2'b00};
        vt[10] = '{2'b10, OP_NOP, 32'd0,        32'd0,        6'b000011, 32'h1234,    32'h5678,     2'b10, OP_NOP, 32'd0,        2'b00, 32'd0,        32'd0,        2'b00};
        vt[11] = '{2'b00, OP_NOP, 32'd0,        32'd0,        OP_NOP,   32'd0,        32'd0,        2'b00, OP_NOP, 32'd0,        2'b00, 32'd0,        32'd0,        2'b00};
        vt[12] = '{2'b00, OP_NOP, 32'd0,        32'd0,        OP_NOP,   32'd0,        32'd0,        2'b00, OP_NOP, 32'd0,        2'b10, 32'd0,        32'd0,        2'b10};

        do_reset();

        // Reset state
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_res0", rsp_res[31:0], 32'd0);
        chk("reset rsp_res1", rsp_res[63:32], 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'(OP_NOP));

        // Directed table, one row per cycle
        for (int r = 0; r < NV; r++) begin
            drive_req(0, vt[r].vld[0], vt[r].op0, vt[r].a0, vt[r].b0);
            drive_req(1, vt[r].vld[1], vt[r].op1, vt[r].a1, vt[r].b1);
            @(negedge clk);
            chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(vt[r].x_rdy));
            chk($sformatf("row%0d alu_op", r), 32'(alu_op), 32'(vt[r].x_op));
            chk($sformatf("row%0d alu_in1", r), alu_in1, vt[r].x_in1);
            chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(vt[r].x_rvld));
            if (vt[r].x_rvld[0]) begin
                chk($sformatf("row%0d rsp_res0", r), rsp_res[31:0], vt[r].x_res0);
                chk($sformatf("row%0d rsp_err0", r), 32'(rsp_err[0]), 32'(vt[r].x_err[0]));
            end
            if (vt[r].x_rvld[1]) begin
                chk($sformatf("row%0d rsp_res1", r), rsp_res[63:32], vt[r].x_res1);
                chk($sformatf("row%0d rsp_err1", r), 32'(rsp_err[1]), 32'(vt[r].x_err[1]));
            end
            @(posedge clk);
            #1;
        end

        // Backpressure: full buffer blocks req0 until it is popped
        do_reset();
        rsp_ready = 2'b00;
        drive_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        @(negedge clk);
        chk("bp first grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        drive_req(0, 1'b1, OP_ADD, 32'd10, 32'd20);
        @(negedge clk);
        chk("bp inflight block", 32'(req_ready), 32'b00);
        chk("bp inflight rsp_valid", 32'(rsp_valid), 32'b00);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("bp hold%0d ready", k), 32'(req_ready), 32'b00);
            chk($sformatf("bp hold%0d rsp_valid", k), 32'(rsp_valid), 32'b01);
            chk($sformatf("bp hold%0d rsp_res0", k), rsp_res[31:0], 32'd3);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp pop-cycle grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp after pop rsp_valid", 32'(rsp_valid), 32'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp second rsp_valid", 32'(rsp_valid), 32'b01);
        chk("bp second rsp_res0", rsp_res[31:0], 32'd30);

        // Reset in the middle of an operation
        do_reset();
        drive_req(0, 1'b1, OP_NOR, 32'd0, 32'd0);
        @(negedge clk);
        chk("mid nor grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid in-reset ready", 32'(req_ready), 32'b00);
        chk("mid in-reset rsp_valid", 32'(rsp_valid), 32'b00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mid no-rsp%0d", k), 32'(rsp_valid), 32'b00);
        end
        @(posedge clk); #1;
        drive_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        drive_req(1, 1'b1, OP_ADD, 32'd2, 32'd2);
        @(negedge clk);
        chk("mid post-reset priority", 32'(req_ready), 32'b01);

        // Random legal mix with random response backpressure
        do_reset();
        issued = 0;
        for (int cyc = 0; cyc < 3000 && !(issued >= 100 && req_valid == 2'b00 && q0.size() == 0 && q1.size() == 0); cyc++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        chk($sformatf("mix unexpected rsp%0d", i), 32'd1, 32'd0);
                    end else begin
                        expv = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("mix rsp%0d res", i), rsp_res[i*WIDTH +: 32], expv);
                        chk($sformatf("mix rsp%0d err", i), 32'(rsp_err[i]), 32'd0);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    expv = alu_ref(req_op[i*6 +: 6], req_in1[i*WIDTH +: 32], req_in2[i*WIDTH +: 32]);
                    if (i == 0) q0.push_back(expv);
                    else        q1.push_back(expv);
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if (issued < 100 && $urandom_range(0, 3) != 0) begin
                        op = ops[$urandom_range(0, 5)];
                        a  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
                        b  = ($urandom_range(0, 7) == 0) ? 32'h00000001 : $urandom;
                        drive_req(i, 1'b1, op, a, b);
                        issued++;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = (issued >= 100) ? 2'b11 : 2'($urandom_range(0, 3));
        end
        chk("mix issued", 32'(issued), 32'd100);
        chk("mix q0 drained", 32'(q0.size()), 32'd0);
        chk("mix q1 drained", 32'(q1.size()), 32'd0);
        chk("mix requests idle", 32'(req_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
